// File: rtl/tank_level_ctrl.sv
// tank_level_ctrl: fill/drain controller for a single tank.
//   Drives an inlet valve (Valve_E) and an outlet valve (Valve_S) from the
//   full/empty sensors, an operating mode and an auto-mode drain request, and
//   keeps a saturating level estimate that is re-anchored by the sensors.
//   A fill that runs too long, an external fault or contradictory sensors
//   park the controller in FAULT until the fault is acknowledged.
// Ports:
//   clock    - rising-edge system clock
//   resetN   - asynchronous reset, active-high (1 = reset)
//   upper    - full sensor, 1 = tank at top
//   lower    - empty sensor, 1 = tank at bottom
//   erro     - external fault, level-sensitive
//   err_clr  - fault acknowledge
//   mode     - 00 auto, 01 manual fill, 10 manual drain, 11 forced hold
//   demand   - auto-mode drain request
//   count    - registered level estimate
//   Valve_E  - inlet valve (1 only in FILL)
//   Valve_S  - outlet valve (1 only in DRAIN)
//   state_o  - state register (IDLE=0 FILL=1 HOLD=2 DRAIN=3 FAULT=4)
//   fault    - sticky fault flag
//   timeout  - sticky fill-timeout flag
module tank_level_ctrl #(
   parameter int unsigned LVL_W   = 4,
   parameter int unsigned MAX_LVL = 15,
   parameter int unsigned LOW_TH  = 4,
   parameter int unsigned HIGH_TH = 12,
   parameter int unsigned FILL_TO = 20
) (
   input  logic             clock,
   input  logic             resetN,
   input  logic             upper,
   input  logic             lower,
   input  logic             erro,
   input  logic             err_clr,
   input  logic [1:0]       mode,
   input  logic             demand,
   output logic [LVL_W-1:0] count,
   output logic             Valve_E,
   output logic             Valve_S,
   output logic [2:0]       state_o,
   output logic             fault,
   output logic             timeout
);

   localparam int unsigned TMR_W = $clog2(FILL_TO + 1);

   localparam logic [LVL_W-1:0] CNT_MAX = LVL_W'(MAX_LVL);
   localparam logic [LVL_W-1:0] CNT_LO  = LVL_W'(LOW_TH);
   localparam logic [LVL_W-1:0] CNT_HI  = LVL_W'(HIGH_TH);
   localparam logic [TMR_W-1:0] TMR_END = TMR_W'(FILL_TO - 1);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      FILL  = 3'd1,
      HOLD  = 3'd2,
      DRAIN = 3'd3,
      FAULT = 3'd4
   } state_t;

   state_t           state;
   state_t           nxt;
   logic [LVL_W-1:0] cnt_nxt;
   logic [TMR_W-1:0] fill_tmr;
   logic [1:0]       act_mode;   // mode captured when the current FILL/DRAIN began
   logic             go_tout;

   assign state_o = state;

   // The level update is computed first so the stop conditions below see the
   // level the tank will have after this cycle; that way FILL/DRAIN leave on
   // the same edge that reaches the threshold instead of overshooting it.
   always_comb begin
      nxt     = state;
      cnt_nxt = count;
      go_tout = 1'b0;

      case (state)
         FILL:    cnt_nxt = upper ? CNT_MAX : ((count == CNT_MAX) ? count : count + 1'b1);
         DRAIN:   cnt_nxt = lower ? '0 : ((count == '0) ? count : count - 1'b1);
         default: cnt_nxt = count;
      endcase

      case (state)
         IDLE: nxt = ((count < CNT_HI) && !upper) ? FILL : HOLD;

         HOLD: begin
            unique case (mode)
               2'b00: begin
                  if ((count <= CNT_LO) && !upper)
                     nxt = FILL;
                  else if (demand && !lower && (count != '0))
                     nxt = DRAIN;
               end
               2'b01: if ((count < CNT_MAX) && !upper) nxt = FILL;
               2'b10: if ((count != '0) && !lower) nxt = DRAIN;
               2'b11: nxt = HOLD;
            endcase
         end

         // Any mode change, or a mode that does not fill, parks in HOLD for a
         // cycle so FILL never hands over directly to DRAIN.
         FILL: begin
            if (fill_tmr == TMR_END) begin
               nxt     = FAULT;
               go_tout = 1'b1;
            end else if ((mode != act_mode) || mode[1]) begin
               nxt = HOLD;
            end else if (upper || ((mode == 2'b00) ? (cnt_nxt >= CNT_HI) : (cnt_nxt == CNT_MAX))) begin
               nxt = HOLD;
            end
         end

         DRAIN: begin
            if ((mode != act_mode) || mode[0] || lower || (cnt_nxt == '0) ||
                ((mode == 2'b00) && !demand))
               nxt = HOLD;
         end

         FAULT: if (err_clr && !erro) nxt = IDLE;

         default: nxt = IDLE;
      endcase

      // External fault or contradictory sensors override everything and
      // freeze the level on the way into FAULT.
      if ((state != FAULT) && (erro || (upper && lower))) begin
         nxt     = FAULT;
         cnt_nxt = count;
         go_tout = 1'b0;
      end
   end

   always_ff @(posedge clock or posedge resetN) begin
      if (resetN) begin
         state    <= IDLE;
         count    <= '0;
         Valve_E  <= 1'b0;
         Valve_S  <= 1'b0;
         fault    <= 1'b0;
         timeout  <= 1'b0;
         fill_tmr <= '0;
         act_mode <= 2'b00;
      end else begin
         state    <= nxt;
         count    <= cnt_nxt;
         Valve_E  <= (nxt == FILL);
         Valve_S  <= (nxt == DRAIN);
         fill_tmr <= ((state == FILL) && (nxt == FILL)) ? fill_tmr + 1'b1 : '0;
         if ((nxt != state) && ((nxt == FILL) || (nxt == DRAIN)))
            act_mode <= mode;
         if ((nxt == FAULT) && (state != FAULT)) begin
            fault <= 1'b1;
            if (go_tout)
               timeout <= 1'b1;
         end else if ((state == FAULT) && (nxt == IDLE)) begin
            fault   <= 1'b0;
            timeout <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_tank_level_ctrl.sv
// tb_tank_level_ctrl: checks two tank_level_ctrl instances sharing one input
//   stream against a behavioural model.  Instance A uses default parameters;
//   instance B has a 5-bit level and HIGH_TH=28 so a 20-cycle fill can run
//   into the fill timeout.
module tb_tank_level_ctrl;

   localparam int S_IDLE = 0, S_FILL = 1, S_HOLD = 2, S_DRAIN = 3, S_FAULT = 4;

   logic       clock = 1'b0;
   logic       resetN = 1'b1;
   logic       upper = 1'b0, lower = 1'b0, erro = 1'b0, err_clr = 1'b0, demand = 1'b0;
   logic [1:0] mode = 2'b00;

   logic [3:0] count_a;
   logic [4:0] count_b;
   logic       ve_a, vs_a, flt_a, to_a, ve_b, vs_b, flt_b, to_b;
   logic [2:0] st_a, st_b;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clock = ~clock;

   tank_level_ctrl dut_a (
      .clock(clock), .resetN(resetN), .upper(upper), .lower(lower), .erro(erro),
      .err_clr(err_clr), .mode(mode), .demand(demand), .count(count_a),
      .Valve_E(ve_a), .Valve_S(vs_a), .state_o(st_a), .fault(flt_a), .timeout(to_a)
   );

   tank_level_ctrl #(.LVL_W(5), .MAX_LVL(31), .LOW_TH(4), .HIGH_TH(28), .FILL_TO(20)) dut_b (
      .clock(clock), .resetN(resetN), .upper(upper), .lower(lower), .erro(erro),
      .err_clr(err_clr), .mode(mode), .demand(demand), .count(count_b),
      .Valve_E(ve_b), .Valve_S(vs_b), .state_o(st_b), .fault(flt_b), .timeout(to_b)
   );

   typedef struct {
      int st;
      int cnt;
      int tmr;     // FILL cycles completed in the current fill
      int amode;   // mode the current activity was started in
      bit flt;
      bit tout;
   } mdl_t;

   mdl_t ma, mb;

   function automatic mdl_t mdl_reset();
      mdl_t r;
      r.st = S_IDLE; r.cnt = 0; r.tmr = 0; r.amode = 0; r.flt = 0; r.tout = 0;
      return r;
   endfunction

   function automatic mdl_t step(mdl_t m, int mx, int lo_th, int hi_th, int fto,
                                 bit up, bit lo, bit er, bit clr, int md, bit dem);
      mdl_t n;
      int   c;
      n = m;
      c = m.cnt;
      n.tmr = 0;
      if (m.st == S_FAULT) begin
         if (clr && !er) begin n.st = S_IDLE; n.flt = 0; n.tout = 0; end
         return n;
      end
      if (er || (up && lo)) begin
         n.st = S_FAULT; n.flt = 1;
         return n;
      end
      if (m.st == S_FILL)  c = up ? mx : ((c < mx) ? c + 1 : mx);
      if (m.st == S_DRAIN) c = lo ? 0  : ((c > 0) ? c - 1 : 0);
      n.cnt = c;
      case (m.st)
         S_IDLE: n.st = (c < hi_th && !up) ? S_FILL : S_HOLD;
         S_HOLD: begin
            if (md == 0) begin
               if (c <= lo_th && !up) n.st = S_FILL;
               else if (dem && !lo && c > 0) n.st = S_DRAIN;
            end else if (md == 1) begin
               if (c < mx && !up) n.st = S_FILL;
            end else if (md == 2) begin
               if (c > 0 && !lo) n.st = S_DRAIN;
            end
         end
         S_FILL: begin
            if (m.tmr + 1 == fto) begin
               n.st = S_FAULT; n.flt = 1; n.tout = 1;
            end else if (md != m.amode || md >= 2 || up ||
                         (md == 0 && c >= hi_th) || (md == 1 && c == mx)) begin
               n.st = S_HOLD;
            end
         end
         S_DRAIN: begin
            if (md != m.amode || md == 1 || md == 3 || lo || c == 0 || (md == 0 && !dem))
               n.st = S_HOLD;
         end
         default: n.st = S_IDLE;
      endcase
      if (n.st == S_FILL && m.st == S_FILL) n.tmr = m.tmr + 1;
      if ((n.st == S_FILL || n.st == S_DRAIN) && n.st != m.st) n.amode = md;
      return n;
   endfunction

   always @(posedge clock or posedge resetN) begin
      if (resetN) begin
         ma = mdl_reset();
         mb = mdl_reset();
      end else begin
         ma = step(ma, 15, 4, 12, 20, upper, lower, erro, err_clr, int'(mode), demand);
         mb = step(mb, 31, 4, 28, 20, upper, lower, erro, err_clr, int'(mode), demand);
      end
   end

   // Per-cycle comparison of both instances against the model.
   always @(negedge clock) begin
      n_cmp++;
      if (int'(st_a) != ma.st || int'(count_a) != ma.cnt || ve_a != (ma.st == S_FILL) ||
          vs_a != (ma.st == S_DRAIN) || flt_a != ma.flt || to_a != ma.tout) begin
         n_err++;
         $display("FAIL model_a @%0t: got st=%0d cnt=%0d ve=%0b vs=%0b f=%0b to=%0b, expected st=%0d cnt=%0d f=%0b to=%0b",
                  $time, st_a, count_a, ve_a, vs_a, flt_a, to_a, ma.st, ma.cnt, ma.flt, ma.tout);
      end
      n_cmp++;
      if (int'(st_b) != mb.st || int'(count_b) != mb.cnt || ve_b != (mb.st == S_FILL) ||
          vs_b != (mb.st == S_DRAIN) || flt_b != mb.flt || to_b != mb.tout) begin
         n_err++;
         $display("FAIL model_b @%0t: got st=%0d cnt=%0d ve=%0b vs=%0b f=%0b to=%0b, expected st=%0d cnt=%0d f=%0b to=%0b",
                  $time, st_b, count_b, ve_b, vs_b, flt_b, to_b, mb.st, mb.cnt, mb.flt, mb.tout);
      end
   end

   task automatic chk(input string nm, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bit hit;
      repeat (3) tick();
      chk("reset_state_a", int'(st_a), S_IDLE);
      chk("reset_count_a", int'(count_a), 0);
      chk("reset_valves_a", int'({ve_a, vs_a}), 0);
      chk("reset_flags_a", int'({flt_a, to_a}), 0);

      // Auto fill from empty: 12 FILL cycles then HOLD at 12.
      resetN = 1'b0;
      tick();
      chk("idle_to_fill_a", int'(st_a), S_FILL);
      chk("fill_valve_e_a", int'(ve_a), 1);
      repeat (11) tick();
      chk("fill11_count_a", int'(count_a), 11);
      chk("fill11_state_a", int'(st_a), S_FILL);
      tick();
      chk("fill12_state_a", int'(st_a), S_HOLD);
      chk("fill12_count_a", int'(count_a), 12);
      chk("fill12_valve_e_a", int'(ve_a), 0);

      // Instance B keeps filling and hits the 20-cycle timeout.
      repeat (7) tick();
      chk("tmr19_state_b", int'(st_b), S_FILL);
      chk("tmr19_count_b", int'(count_b), 19);
      tick();
      chk("timeout_state_b", int'(st_b), S_FAULT);
      chk("timeout_flag_b", int'(to_b), 1);
      chk("timeout_fault_b", int'(flt_b), 1);
      chk("timeout_count_b", int'(count_b), 20);
      chk("timeout_valve_e_b", int'(ve_b), 0);
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      chk("timeout_clr_state_b", int'(st_b), S_IDLE);
      chk("timeout_clr_flags_b", int'({flt_b, to_b}), 0);
      chk("hold_kept_a", int'(st_a), S_HOLD);

      // Drain on demand, stop at 4, then refill.
      demand = 1'b1;
      tick();
      chk("drain_state_a", int'(st_a), S_DRAIN);
      chk("drain_valve_s_a", int'(vs_a), 1);
      hit = 0;
      for (int i = 0; i < 20 && !hit; i++) begin
         if (count_a == 4'd5) hit = 1;
         else tick();
      end
      chk("drain_reach5_a", int'(hit), 1);
      demand = 1'b0;
      tick();
      chk("drain_stop_state_a", int'(st_a), S_HOLD);
      chk("drain_stop_count_a", int'(count_a), 4);
      tick();
      chk("refill_state_a", int'(st_a), S_FILL);
      chk("refill_count_a", int'(count_a), 4);

      // Full sensor during fill loads full scale.
      repeat (3) tick();
      chk("fill7_count_a", int'(count_a), 7);
      upper = 1'b1;
      tick();
      upper = 1'b0;
      chk("upper_count_a", int'(count_a), 15);
      chk("upper_state_a", int'(st_a), S_HOLD);

      // External fault during drain.
      demand = 1'b1;
      repeat (2) tick();
      chk("drain2_count_a", int'(count_a), 14);
      erro = 1'b1;
      tick();
      chk("erro_state_a", int'(st_a), S_FAULT);
      chk("erro_valve_s_a", int'(vs_a), 0);
      chk("erro_fault_a", int'(flt_a), 1);
      chk("erro_count_a", int'(count_a), 14);
      err_clr = 1'b1;
      tick();
      chk("clr_while_erro_a", int'(st_a), S_FAULT);
      erro = 1'b0;
      tick();
      chk("clr_state_a", int'(st_a), S_IDLE);
      chk("clr_fault_a", int'(flt_a), 0);
      err_clr = 1'b0;
      demand = 1'b0;
      tick();
      chk("idle_to_hold_a", int'(st_a), S_HOLD);

      // Manual fill, switch to manual drain: one HOLD cycle in between.
      mode = 2'b01;
      tick();
      chk("man_fill_state_a", int'(st_a), S_FILL);
      mode = 2'b10;
      tick();
      chk("switch_hold_a", int'(st_a), S_HOLD);
      chk("switch_count_a", int'(count_a), 15);
      chk("switch_valves_a", int'({ve_a, vs_a}), 0);
      tick();
      chk("switch_drain_a", int'(st_a), S_DRAIN);
      chk("switch_valves2_a", int'({ve_a, vs_a}), 1);

      // Forced hold.
      mode = 2'b11;
      tick();
      chk("forced_hold_a", int'(st_a), S_HOLD);
      chk("forced_count_a", int'(count_a), 14);
      tick();
      chk("forced_keep_a", int'(st_a), S_HOLD);

      // Contradictory sensors.
      mode = 2'b00;
      upper = 1'b1;
      lower = 1'b1;
      tick();
      chk("sensor_fault_state_a", int'(st_a), S_FAULT);
      chk("sensor_fault_flags_a", int'({flt_a, to_a}), 2);
      upper = 1'b0;
      lower = 1'b0;
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      chk("sensor_clr_a", int'(st_a), S_IDLE);

      // Mid-cycle reset, release, first transition on next edge.
      tick();
      resetN = 1'b1;
      #1;
      chk("midreset_state_a", int'(st_a), S_IDLE);
      chk("midreset_count_a", int'(count_a), 0);
      #2;
      resetN = 1'b0;
      tick();
      chk("postreset_fill_a", int'(st_a), S_FILL);

      // Randomized phase.
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(15) == 0) mode = 2'($urandom_range(3));
         if ($urandom_range(7) == 0) demand = ~demand;
         erro    = ($urandom_range(63) == 0);
         err_clr = ($urandom_range(3) == 0);
         upper   = ($urandom_range(11) == 0);
         lower   = ($urandom_range(11) == 0);
         if ($urandom_range(499) == 0) begin
            resetN = 1'b1;
            tick();
            resetN = 1'b0;
         end
         tick();
      end

      @(posedge clock);
      #1;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
